top_demux_stream: RTL and testbench
===================================

// Module: top_demux_stream
// PURPOSE
// - Registered, handshaked 1-to-N demultiplexer feeding the PE array's row/column input lanes.
// - Successor of the combinational lane demux.
// - Adds per-lane valid/ready backpressure, a one-entry holding register per lane,
//   and three steering modes: explicit select, round-robin, broadcast.
// - Sits between the input-buffer read port and the N systolic-array edge lanes.
// PARAMETERS
// - DW   8           data width per lane, bits (>=1)
// - N    8           number of output lanes (>=2; need not be a power of 2)
// - SEL  $clog2(N)   lane-index width; derived, never overridden
// PORTS
// - clk        in   1      single clock; all state on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - mode       in   2      steering mode, sampled every cycle (codes in package)
// - in_valid   in   1      input word valid
// - in_ready   out  1      input word accepted this cycle when in_valid & in_ready
// - in_data    in   DW     input word
// - in_sel     in   SEL    target lane in SELECT mode
// - in_last    in   1      last word of a tile; resets round-robin pointer
// - out_valid  out  N      per-lane valid, bit i = lane i
// - out_ready  in   N      per-lane ready from consumer
// - out_data   out  DW*N   lane i at [(i+1)*DW-1 -: DW]
// - rr_ptr     out  SEL    current round-robin lane
// - sel_err    out  1      one-cycle pulse: word accepted with in_sel >= N and dropped
// BEHAVIOUR
// - Reset, asynchronous on rst_n low: out_valid=0, out_data=0, rr_ptr=0, sel_err=0.
//   Effect is immediate; in-flight words are discarded.
// - Lane i is free when !out_valid[i] | out_ready[i].
//   This is a combinational pass-through, so a full lane accepts a new word in the cycle it drains.
// - in_ready is combinational, by mode:
//   - SELECT: free[in_sel], or 1 when in_sel >= N.
//   - RR: free[rr_ptr].
//   - BCAST: AND of all free[i].
//   - RSVD: 0.
// - Latency is 1 cycle. An accepted word appears on the target lane(s) with out_valid set on the next edge.
// - A lane clears out_valid when out_ready[i]=1 and no new word is written to it.
//   Its data register holds the last value; consumers qualify data with out_valid.
// - SELECT with in_sel >= N: the word is accepted (in_ready=1) and dropped.
//   No lane is written; sel_err=1 on the next cycle.
// - rr_ptr:
//   - On every accepted word in RR mode: +1, wrapping N-1 -> 0.
//   - On any accepted word with in_last=1, in any mode: 0. Takes priority over the increment.
//   - Otherwise holds.
// - BCAST writes the same word to all N lanes in one transfer. All lanes must be free in the same cycle.
// - Mode change while lanes hold data is legal. There is no flush; held words drain normally.
// - No word is ever duplicated (except BCAST) or lost (except the sel_err drop) under any out_ready pattern.
// - No combinational path from in_valid to out_*.
// STRUCTURE
// - Package top_demux_pkg:
//   - MODE_SEL=2'd0, MODE_RR=2'd1, MODE_BCAST=2'd2, MODE_RSVD=2'd3.
//   - Function for the lane-slice index.
// - Sub-module demux_lane_reg: one-entry valid/ready holding register (wr_en, wr_data, free, valid, data).
//   Instantiated N times via generate.
// - Top level holds: mode decode, in_ready/write-enable generation, rr_ptr counter, sel_err flop.
// TESTING
// - Reset, DW=8, N=8: hold rst_n=0 mid-stream with lanes full.
//   -> out_valid=8'h00, out_data=0, rr_ptr=0 immediately; first word after release lands 1 cycle later.
// - SELECT: in_sel=5, data 8'hA5, out_ready=8'hFF.
//   -> next cycle out_valid=8'h20 and out_data[47:40]=8'hA5; back-to-back words to lane 5 at full rate.
// - RR: 10 words 0..9, all ready.
//   -> lanes 0..7 get 0..7, then lane 0 gets 8 and lane 1 gets 9; rr_ptr ends at 2.
//   Same stimulus with in_last on word 3 -> word 4 goes to lane 0.
// - Backpressure, RR: out_ready[2]=0, lane 2 full, rr_ptr=2.
//   -> in_ready=0 and rr_ptr stuck at 2; in_ready rises in the same cycle out_ready[2] rises, no word lost.
// - BCAST: out_ready=8'hFE with lane 0 full.
//   -> in_ready=0; when out_ready=8'hFF, word 8'h3C appears on all 8 lanes the next cycle.
// - N=6, SELECT with in_sel=7.
//   -> in_ready=1, no out_valid change, sel_err=1 for exactly one cycle.
//   mode=3 -> in_ready=0 permanently.

Source files
------------

// File: rtl/top_demux_pkg.sv
// Shared definitions for the handshaked lane demultiplexer: steering mode
// codes and the helper that locates a lane's slice in the packed data bus.
package top_demux_pkg;

    typedef enum logic [1:0] {
        MODE_SEL   = 2'd0,
        MODE_RR    = 2'd1,
        MODE_BCAST = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    // Lowest bit of lane 'lane' within a DW*N packed bus.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/top_demux_stream_lane_reg.sv
// One-entry valid/ready holding register for a single output lane.
// The lane reports itself free when empty or when its word drains this cycle,
// so a full lane can be refilled in the same cycle it is consumed.
module demux_lane_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          ready,
    output logic          free,
    output logic          valid,
    output logic [DW-1:0] data
);

    assign free = !valid || ready;

    // Valid flag: set on write, cleared when drained without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

    // Data register: loads on write, otherwise keeps the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data register is reset too, since the bus must read zero out of reset.
        if (!rst_n) begin
            data <= '0;
        end else if (wr_en) begin
            data <= wr_data;
        end
    end

endmodule

// File: rtl/top_demux_stream.sv
// Registered 1-to-N stream demultiplexer feeding the PE-array edge lanes.
// Steers each accepted input word by explicit select, round-robin or
// broadcast into per-lane one-entry holding registers with valid/ready.
module top_demux_stream
    import top_demux_pkg::*;
#(
    parameter int DW  = 8,
    parameter int N   = 8,
    parameter int SEL = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [SEL-1:0]  in_sel,
    input  logic            in_last,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [DW*N-1:0] out_data,
    output logic [SEL-1:0]  rr_ptr,
    output logic            sel_err
);

    localparam logic [SEL-1:0] RR_LAST = SEL'(N - 1);

    mode_e        mode_q;
    logic [N-1:0] free;
    logic [N-1:0] tgt;
    logic [N-1:0] wr_en;
    logic         sel_in_range;
    logic         accept;

    assign mode_q       = mode_e'(mode);
    assign sel_in_range = int'(in_sel) < N;

    // Target lane mask for the current mode (empty for reserved or out-of-range select).
    always_comb begin
        // NOTE: default first so no path leaves the mask unassigned and infers a latch.
        tgt = '0;
        for (int i = 0; i < N; i++) begin
            case (mode_q)
                MODE_SEL:   tgt[i] = (int'(in_sel) == i);
                MODE_RR:    tgt[i] = (int'(rr_ptr) == i);
                MODE_BCAST: tgt[i] = 1'b1;
                default:    tgt[i] = 1'b0;
            endcase
        end
    end

    // Input handshake: ready when every targeted lane is free; bad selects are swallowed.
    always_comb begin
        in_ready = 1'b0;
        case (mode_q)
            MODE_SEL:   in_ready = sel_in_range ? |(tgt & free) : 1'b1;
            MODE_RR:    in_ready = |(tgt & free);
            MODE_BCAST: in_ready = &free;
            default:    in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign wr_en  = {N{accept}} & tgt;

    // Round-robin pointer: tile end rewinds to lane 0, RR transfers advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && in_last) begin
            rr_ptr <= '0;
        end else if (accept && mode_q == MODE_RR) begin
            rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + SEL'(1);
        end
    end

    // Flags a word that was accepted and dropped because its select is out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept && mode_q == MODE_SEL && !sel_in_range;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        demux_lane_reg #(.DW(DW)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[i]),
            .wr_data (in_data),
            .ready   (out_ready[i]),
            .free    (free[i]),
            .valid   (out_valid[i]),
            .data    (out_data[lane_lo(i, DW) +: DW])
        );
    end

endmodule

// File: tb/tb_top_demux_stream.sv
// Directed bench for top_demux_stream: an N=8 instance for select, round-robin,
// backpressure, broadcast and reset, plus an N=6 instance for the dropped
// out-of-range select, pointer wrap and the reserved mode.
module tb_top_demux_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_last;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [63:0] out_data;
    logic [2:0]  rr_ptr;
    logic        sel_err;

    logic [1:0]  mode6;
    logic        in_valid6;
    logic        in_ready6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic        in_last6;
    logic [5:0]  out_valid6;
    logic [5:0]  out_ready6;
    logic [47:0] out_data6;
    logic [2:0]  rr_ptr6;
    logic        sel_err6;

    int n_cmp = 0;
    int n_err = 0;

    top_demux_stream #(.DW(8), .N(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .sel_err   (sel_err)
    );

    top_demux_stream #(.DW(8), .N(6)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .in_data   (in_data6),
        .in_sel    (in_sel6),
        .in_last   (in_last6),
        .out_valid (out_valid6),
        .out_ready (out_ready6),
        .out_data  (out_data6),
        .rr_ptr    (rr_ptr6),
        .sel_err   (sel_err6)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    function automatic logic [7:0] lane8(input int k);
        return out_data[k*8 +: 8];
    endfunction

    function automatic logic [7:0] lane6(input int k);
        return out_data6[k*8 +: 8];
    endfunction

    logic [2:0] exp_lane_last [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    initial begin
        rst_n      = 1'b0;
        mode       = 2'd0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_sel     = 3'd0;
        in_last    = 1'b0;
        out_ready  = 8'hFF;
        mode6      = 2'd0;
        in_valid6  = 1'b0;
        in_data6   = 8'h00;
        in_sel6    = 3'd0;
        in_last6   = 1'b0;
        out_ready6 = 6'h3F;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'h00);
        check("rst_out_data", out_data, 64'h0);
        check("rst_rr_ptr", 64'(rr_ptr), 64'd0);
        check("rst_sel_err", 64'(sel_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // SELECT to lane 5, then a back-to-back word to the same lane
        mode     = 2'd0;
        in_sel   = 3'd5;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        settle();
        check("sel_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("sel_out_valid", 64'(out_valid), 64'h20);
        check("sel_lane5", 64'(lane8(5)), 64'hA5);
        in_data = 8'h5A;
        settle();
        check("sel_b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("sel_b2b_out_valid", 64'(out_valid), 64'h20);
        check("sel_b2b_lane5", 64'(lane8(5)), 64'h5A);
        in_valid = 1'b0;
        tick();
        check("sel_drain", 64'(out_valid), 64'h00);

        // Round-robin, 10 words, all lanes ready
        mode     = 2'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(k);
            tick();
            check($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'(8'h01 << (k % 8)));
            check($sformatf("rr_data_%0d", k), 64'(lane8(k % 8)), 64'(k));
        end
        in_valid = 1'b0;
        check("rr_ptr_end", 64'(rr_ptr), 64'd2);
        tick();

        // Fill two lanes with consumers stalled, then reset asynchronously mid-cycle
        mode      = 2'd0;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_data   = 8'h44;
        tick();
        in_sel  = 3'd1;
        in_data = 8'h55;
        settle();
        check("fill_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("fill_out_valid", 64'(out_valid), 64'h03);
        check("fill_rr_ptr", 64'(rr_ptr), 64'd2);
        settle();
        rst_n = 1'b0;
        settle();
        check("arst_out_valid", 64'(out_valid), 64'h00);
        check("arst_out_data", out_data, 64'h0);
        check("arst_rr_ptr", 64'(rr_ptr), 64'd0);
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        in_sel    = 3'd3;
        in_data   = 8'h77;
        in_valid  = 1'b1;
        settle();
        tick();
        check("post_rst_valid", 64'(out_valid), 64'h08);
        check("post_rst_lane3", 64'(lane8(3)), 64'h77);
        in_valid = 1'b0;
        tick();

        // Round-robin with in_last on word 3
        mode     = 2'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'(k + 16);
            in_last = (k == 3);
            tick();
            check($sformatf("rrl_valid_%0d", k), 64'(out_valid), 64'(8'h01 << exp_lane_last[k]));
            check($sformatf("rrl_data_%0d", k), 64'(lane8(int'(exp_lane_last[k]))), 64'(k + 16));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("rrl_ptr_end", 64'(rr_ptr), 64'd6);
        tick();

        // Backpressure: lane 2 full and stalled, rr_ptr parked on it
        mode      = 2'd0;
        in_sel    = 3'd2;
        in_data   = 8'h22;
        in_last   = 1'b1;
        out_ready = 8'hFB;
        in_valid  = 1'b1;
        tick();
        check("bp_last_ptr", 64'(rr_ptr), 64'd0);
        check("bp_lane2_full", 64'(out_valid), 64'h04);
        in_last = 1'b0;
        mode    = 2'd1;
        in_data = 8'h30;
        tick();
        in_data = 8'h31;
        tick();
        check("bp_ptr_at_2", 64'(rr_ptr), 64'd2);
        check("bp_valid_06", 64'(out_valid), 64'h06);
        in_data = 8'hD2;
        settle();
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("bp_ptr_stuck", 64'(rr_ptr), 64'd2);
        check("bp_valid_held", 64'(out_valid), 64'h04);
        check("bp_lane2_old", 64'(lane8(2)), 64'h22);
        out_ready = 8'hFF;
        settle();
        check("bp_in_ready_rise", 64'(in_ready), 64'd1);
        tick();
        check("bp_valid_new", 64'(out_valid), 64'h04);
        check("bp_lane2_new", 64'(lane8(2)), 64'hD2);
        check("bp_ptr_adv", 64'(rr_ptr), 64'd3);
        in_valid = 1'b0;
        tick();

        // Broadcast blocked by one stalled full lane, then released
        mode      = 2'd0;
        in_sel    = 3'd0;
        in_data   = 8'h11;
        out_ready = 8'hFE;
        in_valid  = 1'b1;
        tick();
        check("bc_lane0_full", 64'(out_valid), 64'h01);
        mode    = 2'd2;
        in_data = 8'h3C;
        settle();
        check("bc_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("bc_blocked_valid", 64'(out_valid), 64'h01);
        check("bc_blocked_lane0", 64'(lane8(0)), 64'h11);
        out_ready = 8'hFF;
        settle();
        check("bc_in_ready_high", 64'(in_ready), 64'd1);
        tick();
        check("bc_out_valid", 64'(out_valid), 64'hFF);
        check("bc_out_data", out_data, {8{8'h3C}});
        check("bc_rr_ptr", 64'(rr_ptr), 64'd3);
        in_valid = 1'b0;
        tick();
        check("bc_drain", 64'(out_valid), 64'h00);

        // N=6: out-of-range select is accepted and dropped with a one-cycle error
        mode6     = 2'd0;
        in_sel6   = 3'd7;
        in_data6  = 8'h99;
        in_valid6 = 1'b1;
        settle();
        check("n6_bad_sel_ready", 64'(in_ready6), 64'd1);
        tick();
        check("n6_bad_sel_valid", 64'(out_valid6), 64'h00);
        check("n6_sel_err_hi", 64'(sel_err6), 64'd1);
        in_valid6 = 1'b0;
        tick();
        check("n6_sel_err_lo", 64'(sel_err6), 64'd0);

        // N=6: round-robin wraps from lane 5 back to 0
        mode6     = 2'd1;
        in_valid6 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data6 = 8'(k + 8'h60);
            tick();
        end
        in_valid6 = 1'b0;
        check("n6_rr_wrap", 64'(rr_ptr6), 64'd0);
        check("n6_rr_valid", 64'(out_valid6), 64'h20);
        check("n6_rr_lane5", 64'(lane6(5)), 64'h65);
        tick();

        // N=6: reserved mode never accepts
        mode6     = 2'd3;
        in_valid6 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("n6_rsvd_ready_%0d", k), 64'(in_ready6), 64'd0);
            tick();
            check($sformatf("n6_rsvd_valid_%0d", k), 64'(out_valid6), 64'h00);
        end
        in_valid6 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
